// File: rtl/elevator_stepper_ctrl.sv
// Unipolar stepper driver for the elevator car motor. Accepts move commands
// (direction, step count, half/full mode), sequences the four coils at a
// programmable step period, and keeps a wrapping signed position count.
module elevator_stepper_ctrl #(
  parameter int unsigned STEP_DIV = 240000,
  parameter int unsigned POS_W    = 16,
  parameter bit          HOLD_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [POS_W-1:0] cmd_steps,
  input  logic             cmd_half,
  input  logic             abort,
  output logic [3:0]       motor_out,
  output logic             step_strobe,
  output logic [POS_W-1:0] position,
  output logic             done
);

  localparam int unsigned             DIV_W    = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic signed [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};

  // S_ZACK is the one-cycle acknowledge of a zero-length move.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DWELL, S_ZACK} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [POS_W-1:0]        cnt_q, cnt_d;
  logic [POS_W-1:0]        steps_q, steps_d;
  logic                    dir_q, dir_d;
  logic                    half_q, half_d;
  logic [2:0]              idx_q, idx_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [3:0]              motor_q, motor_d;
  logic                    strobe_q, strobe_d;
  logic                    done_q, done_d;

  logic                    take_step;
  logic                    step_dir;
  logic                    step_half;
  logic [POS_W-1:0]        cnt_inc;

  function automatic logic [3:0] phase(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'b1001;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1010;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b0100;
      3'd6:    return 4'b0101;
      3'd7:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // An odd index in full-step mode moves by one so the sequence lands on
  // the even (two-coil) entries from then on.
  function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                          input logic       dir,
                                          input logic       half);
    logic [2:0] delta;
    delta = (half || idx[0]) ? 3'd1 : 3'd2;
    return dir ? (idx - delta) : (idx + delta);
  endfunction

  assign cmd_ready   = (state_q == S_IDLE);
  assign motor_out   = motor_q;
  assign step_strobe = strobe_q;
  assign position    = pos_q;
  assign done        = done_q;

  // Next-state logic: command accept, step timing, dwell, abort and coil update.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    half_d    = half_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    motor_d   = motor_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    take_step = 1'b0;
    step_dir  = dir_q;
    step_half = half_q;
    cnt_inc   = cnt_q + POS_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          half_d  = cmd_half;
          steps_d = cmd_steps;
          div_d   = '0;
          if (cmd_steps == '0) begin
            state_d = S_ZACK;
            done_d  = 1'b1;
          end else begin
            // The first step is taken on the accepting edge itself.
            take_step = 1'b1;
            step_dir  = cmd_dir;
            step_half = cmd_half;
            cnt_d     = POS_W'(1);
            state_d   = (cmd_steps == POS_W'(1)) ? S_DWELL : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!HOLD_EN) motor_d = 4'b0000;
        end else if (div_q == DIV_LAST) begin
          take_step = 1'b1;
          div_d     = '0;
          cnt_d     = cnt_inc;
          if (cnt_inc == steps_q) state_d = S_DWELL;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DWELL: begin
        if (abort || (div_q == DIV_LAST)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!HOLD_EN) motor_d = 4'b0000;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_ZACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_step) begin
      idx_d    = next_idx(idx_q, step_dir, step_half);
      motor_d  = phase(idx_d);
      pos_d    = step_dir ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
      strobe_d = 1'b1;
    end
  end

  // State and output registers; reset drops the move and de-energises the coils.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      dir_q    <= 1'b0;
      half_q   <= 1'b0;
      idx_q    <= 3'd0;
      pos_q    <= '0;
      motor_q  <= 4'b0000;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      dir_q    <= dir_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      motor_q  <= motor_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_elevator_stepper_ctrl.sv
// Bench for elevator_stepper_ctrl: a HOLD_EN=1 and a HOLD_EN=0 instance share
// stimulus; a reference model predicts step/done events into a queue that a
// separate monitor drains and compares.
`timescale 1ns/1ps
module tb_elevator_stepper_ctrl;

  localparam int D  = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic          cmd_half = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] cmd_steps = '0;

  logic          cmd_ready, step_strobe, done;
  logic [3:0]    motor_out;
  logic [PW-1:0] position;
  logic          cmd_ready0, step_strobe0, done0;
  logic [3:0]    motor_out0;
  logic [PW-1:0] position0;

  always #5 clk = ~clk;

  elevator_stepper_ctrl #(.STEP_DIV(D), .POS_W(PW), .HOLD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_half(cmd_half), .abort(abort),
    .motor_out(motor_out), .step_strobe(step_strobe), .position(position), .done(done)
  );

  elevator_stepper_ctrl #(.STEP_DIV(D), .POS_W(PW), .HOLD_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_half(cmd_half), .abort(abort),
    .motor_out(motor_out0), .step_strobe(step_strobe0), .position(position0), .done(done0)
  );

  typedef struct {
    int           cyc;
    bit           is_done;
    logic [3:0]   mot;
    logic [3:0]   mot0;
    logic [PW-1:0] pos;
  } ev_t;

  ev_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  logic [3:0]    PH [0:7] = '{4'b1001, 4'b1000, 4'b1010, 4'b0010,
                              4'b0110, 4'b0100, 4'b0101, 4'b0001};
  int            m_idx = 0;
  logic [3:0]    m_mot = 4'b0000;
  logic [PW-1:0] m_pos = '0;

  int done_cyc  = 0;
  int abort_cyc = 0;
  bit abort_on  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_idx = 0;
    m_mot = 4'b0000;
    m_pos = '0;
    exp_q.delete();
    abort_on = 1'b0;
  endfunction

  // Monitor: counts cycles at each falling edge and checks every step/done event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_assert++;
        n_fail++;
        $display("FAIL missing_event: %s expected at cycle %0d, absent through cycle %0d",
                 e.is_done ? "done" : "step", e.cyc, cyc);
      end
      if (step_strobe || done) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_output: strobe=%0b done=%0b at cycle %0d, required none",
                   step_strobe, done, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("step_strobe", 32'(step_strobe), 32'(!e.is_done));
          chk("done", 32'(done), 32'(e.is_done));
          chk("motor_out", 32'(motor_out), 32'(e.mot));
          chk("position", 32'(position), 32'(e.pos));
          chk("nohold_strobe", 32'(step_strobe0), 32'(!e.is_done));
          chk("nohold_done", 32'(done0), 32'(e.is_done));
          chk("nohold_motor", 32'(motor_out0), 32'(e.mot0));
          chk("nohold_position", 32'(position0), 32'(e.pos));
        end
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 with cmd_ready high.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n <= 2000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_half  = 1'($urandom_range(0, 1));
      cmd_steps = PW'($urandom);
      @(negedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!cmd_ready) begin
      n_assert++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready got 0 required 1 after %0d cycles", n);
    end else begin
      chk("nohold_idle_motor", 32'(motor_out0), 32'h0);
    end
  endtask

  task automatic issue(input bit dir, input bit half, input logic [PW-1:0] n,
                       input bit do_abort, input int abort_off);
    int  t;
    int  nd;
    int  sc;
    int  delta;
    ev_t e;
    t         = cyc;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_half  = half;
    cmd_steps = n;
    abort     = 1'($urandom_range(0, 1));
    abort_on  = do_abort && (n != '0);
    nd        = (n == '0) ? t + 1 : t + 1 + int'(n) * D;
    abort_cyc = t + 1 + abort_off;
    if (abort_cyc > nd - 1) abort_cyc = nd - 1;
    done_cyc  = abort_on ? abort_cyc + 1 : nd;
    for (int k = 0; k < int'(n); k++) begin
      sc = t + 1 + k * D;
      if (abort_on && sc > abort_cyc) break;
      delta = (half || (m_idx % 2 == 1)) ? 1 : 2;
      m_idx = dir ? (m_idx + 8 - delta) % 8 : (m_idx + delta) % 8;
      m_mot = PH[m_idx];
      m_pos = dir ? m_pos - PW'(1) : m_pos + PW'(1);
      e.cyc = sc; e.is_done = 1'b0; e.mot = m_mot; e.mot0 = m_mot; e.pos = m_pos;
      exp_q.push_back(e);
    end
    e.cyc = done_cyc; e.is_done = 1'b1; e.mot = m_mot; e.mot0 = 4'b0000; e.pos = m_pos;
    exp_q.push_back(e);
  endtask

  // Runs the clock up to the predicted done cycle, firing abort when scheduled
  // and offering junk commands while busy.
  task automatic finish_cmd();
    int guard;
    guard = 0;
    while (cyc < done_cyc && guard < 100000) begin
      @(negedge clk);
      #1;
      guard++;
      abort = abort_on && (cyc == abort_cyc);
      if (cyc < done_cyc) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_half  = 1'($urandom_range(0, 1));
        cmd_steps = PW'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    abort = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic reset_mid_move(input int after);
    repeat (after) begin
      @(negedge clk);
      #1;
      abort     = 1'b0;
      cmd_valid = 1'($urandom_range(0, 1));
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    cmd_valid = 1'b1;
    #1;
    chk("async_rst_motor", 32'(motor_out), 32'h0);
    chk("async_rst_position", 32'(position), 32'h0);
    chk("async_rst_ready", 32'(cmd_ready), 32'h1);
    chk("async_rst_done", 32'(done), 32'h0);
    chk("async_rst_strobe", 32'(step_strobe), 32'h0);
    chk("async_rst_nohold_ready", 32'(cmd_ready0), 32'h1);
    @(negedge clk);
    #1;
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            rdir, rhalf, rab;
    logic [PW-1:0] rn;
    int            roff;

    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_motor", 32'(motor_out), 32'h0);
    chk("reset_position", 32'(position), 32'h0);
    chk("reset_ready", 32'(cmd_ready), 32'h1);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_strobe", 32'(step_strobe), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // forward full-step, 4 steps from index 0
    wait_ready();
    issue(1'b0, 1'b0, PW'(4), 1'b0, 0);
    finish_cmd();
    chk("fwd_full_position", 32'(position), 32'h4);
    chk("fwd_full_motor", 32'(motor_out), 32'b1001);
    chk("fwd_full_ready_at_done", 32'(cmd_ready), 32'h1);

    // reset in the middle of a 10-step half-step move
    wait_ready();
    issue(1'b0, 1'b1, PW'(10), 1'b0, 0);
    reset_mid_move(6);

    // half-step reverse, 3 steps from index 0
    wait_ready();
    issue(1'b1, 1'b1, PW'(3), 1'b0, 0);
    finish_cmd();
    chk("half_rev_position", 32'(position), 32'hFFFD);
    chk("half_rev_motor", 32'(motor_out), 32'b0100);

    // full-step forward starting from odd index 7
    do_reset();
    wait_ready();
    issue(1'b1, 1'b1, PW'(1), 1'b0, 0);
    finish_cmd();
    wait_ready();
    issue(1'b0, 1'b0, PW'(2), 1'b0, 0);
    finish_cmd();
    chk("odd_full_position", 32'(position), 32'h1);
    chk("odd_full_motor", 32'(motor_out), 32'b1010);

    // abort two cycles after the second step of a 10-step move
    do_reset();
    wait_ready();
    issue(1'b0, 1'b0, PW'(10), 1'b1, D + 2);
    finish_cmd();
    chk("abort_position", 32'(position), 32'h2);
    chk("abort_ready", 32'(cmd_ready), 32'h1);
    chk("abort_done", 32'(done), 32'h1);

    // zero-length move
    wait_ready();
    issue(1'b1, 1'b0, PW'(0), 1'b0, 0);
    finish_cmd();
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_no_strobe", 32'(step_strobe), 32'h0);
    chk("zero_nohold_motor", 32'(motor_out0), 32'h0);

    // randomized commands, some aborted
    for (int i = 0; i < 40; i++) begin
      rdir  = 1'($urandom_range(0, 1));
      rhalf = 1'($urandom_range(0, 1));
      rn    = PW'($urandom_range(0, 6));
      rab   = ($urandom_range(0, 3) == 0);
      roff  = $urandom_range(0, int'(rn) * D + 1);
      wait_ready();
      issue(rdir, rhalf, rn, rab, roff);
      finish_cmd();
    end

    repeat (3 * D) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
